// File: rtl/cau_pkg.sv
// Shared mode encodings and limit helper for the count/add datapath.
package cau_pkg;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_HOLD = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b11;

    // Largest value of the W+1-bit result register for operand width w.
    function automatic int unsigned cau_max(input int unsigned w);
        return (32'd1 << (w + 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/count_add_unit_rca_n.sv
// Parametrised ripple-carry adder assembled from full-adder cells.
module rca_n #(
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[W];

endmodule

// File: rtl/count_add_unit.sv
// Fully registered add / hold / up / down datapath with load, count enable and
// elaboration-time wrap-or-saturate behaviour at the counter limits.
module count_add_unit
    import cau_pkg::*;
#(
    parameter int W   = 3,
    parameter int SAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   sel,
    input  logic         en,
    input  logic         ld,
    output logic [W:0]   dout,
    output logic         wrap,
    output logic         zero
);

    logic [W:0]   r_dout;
    logic         r_wrap;
    logic         r_zero;

    logic [W-1:0] w_sum;
    logic         w_sum_co;
    logic         w_down;
    logic [W:0]   w_step_b;
    logic [W:0]   w_step;
    logic         w_step_co;
    logic         w_limit;
    logic [W:0]   w_cnt_next;
    logic [W:0]   w_next;
    logic         w_wrap_next;

    rca_n #(.W(W)) u_add (
        .a    (a),
        .b    (b),
        .cin  (1'b0),
        .s    (w_sum),
        .cout (w_sum_co)
    );

    // Increment is dout + 0 + cin; decrement is dout + all-ones with no cin.
    assign w_down   = (sel == MODE_DOWN);
    assign w_step_b = w_down ? '1 : '0;

    rca_n #(.W(W + 1)) u_step (
        .a    (r_dout),
        .b    (w_step_b),
        .cin  (~w_down),
        .s    (w_step),
        .cout (w_step_co)
    );

    // The step carry doubles as the limit detector: it is set only when
    // incrementing from max, and clear only when decrementing from zero.
    assign w_limit = w_down ? ~w_step_co : w_step_co;

    if (SAT != 0) begin : g_sat
        assign w_cnt_next = w_limit ? r_dout : w_step;
    end else begin : g_wrap
        assign w_cnt_next = w_step;
    end

    always_comb begin
        w_next      = r_dout;
        w_wrap_next = 1'b0;
        if (ld) begin
            w_next = {1'b0, a};
        end else begin
            case (sel)
                MODE_ADD:  w_next = {w_sum_co, w_sum};
                MODE_HOLD: w_next = r_dout;
                default: begin
                    if (en) begin
                        w_next      = w_cnt_next;
                        w_wrap_next = w_limit;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout <= '0;
            r_wrap <= 1'b0;
            r_zero <= 1'b1;
        end else begin
            r_dout <= w_next;
            r_wrap <= w_wrap_next;
            r_zero <= (w_next == '0);
        end
    end

    assign dout = r_dout;
    assign wrap = r_wrap;
    assign zero = r_zero;

endmodule

// File: tb/tb_count_add_unit.sv
// Directed and random checks of count_add_unit, wrap and saturate builds side by side.
module tb_count_add_unit;

    localparam int W    = 3;
    localparam int MAXV = (1 << (W + 1)) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b;
    logic [1:0]   sel;
    logic         en, ld;
    logic [W:0]   d0, d1;
    logic         w0, w1, z0, z1;

    int compares = 0;
    int fails    = 0;

    int m_d[2];
    bit m_w[2];
    bit m_z[2];

    always #5 clk = ~clk;

    count_add_unit #(.W(W), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel), .en(en), .ld(ld),
        .dout(d0), .wrap(w0), .zero(z0)
    );

    count_add_unit #(.W(W), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel), .en(en), .ld(ld),
        .dout(d1), .wrap(w1), .zero(z1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compares++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " sat0 dout"}, {28'd0, d0}, 32'(m_d[0]));
        chk({tag, " sat0 wrap"}, {31'd0, w0}, 32'(m_w[0]));
        chk({tag, " sat0 zero"}, {31'd0, z0}, 32'(m_z[0]));
        chk({tag, " sat1 dout"}, {28'd0, d1}, 32'(m_d[1]));
        chk({tag, " sat1 wrap"}, {31'd0, w1}, 32'(m_w[1]));
        chk({tag, " sat1 zero"}, {31'd0, z1}, 32'(m_z[1]));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_d[k] = 0;
            m_w[k] = 1'b0;
            m_z[k] = 1'b1;
        end
    endtask

    // Reference behaviour: k = 0 wraps, k = 1 saturates.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int n;
            bit wr;
            n  = m_d[k];
            wr = 1'b0;
            if (ld) begin
                n = int'(a);
            end else begin
                case (sel)
                    2'd0: n = int'(a) + int'(b);
                    2'd1: n = m_d[k];
                    2'd2: if (en) begin
                        if (m_d[k] == MAXV) begin
                            wr = 1'b1;
                            n  = (k == 1) ? MAXV : 0;
                        end else n = m_d[k] + 1;
                    end
                    default: if (en) begin
                        if (m_d[k] == 0) begin
                            wr = 1'b1;
                            n  = (k == 1) ? 0 : MAXV;
                        end else n = m_d[k] - 1;
                    end
                endcase
            end
            m_d[k] = n;
            m_w[k] = wr;
            m_z[k] = (n == 0);
        end
    endtask

    task automatic drive(input bit i_ld, input int i_a, input int i_b, input int i_sel, input bit i_en);
        ld  = i_ld;
        a   = i_a[W-1:0];
        b   = i_b[W-1:0];
        sel = i_sel[1:0];
        en  = i_en;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 1, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Add mode, including the widest sum
        drive(0, 7, 7, 0, 1);  tick("add 7+7");
        drive(0, 5, 3, 0, 0);  tick("add 5+3");
        drive(0, 5, 4, 0, 0);  tick("add 5+4");

        // Asynchronous reset mid-cycle with dout = 9
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async reset");
        @(negedge clk);
        rst = 1'b1;

        // Count up through the top limit
        drive(0, 7, 7, 0, 0);  tick("up setup 14");
        drive(0, 0, 0, 2, 1);  tick("up 15");
        tick("up limit");
        tick("up after limit");
        tick("up after limit 2");

        // Count down through zero
        drive(1, 1, 0, 3, 1);  tick("down load 1");
        drive(0, 0, 0, 3, 1);  tick("down 0");
        tick("down limit");
        tick("down limit again");
        drive(0, 0, 0, 3, 0);  tick("down disabled");

        // Load beats a simultaneous count step
        drive(1, 5, 0, 2, 1);  tick("load vs count");
        drive(0, 0, 0, 2, 1);  tick("count after load");

        // Hold ignores toggling a, b and en
        for (int i = 0; i < 4; i++) begin
            drive(0, 7 - i, i + 2, 1, i[0]);
            tick("hold");
        end
        drive(1, 0, 0, 3, 1);  tick("load 0");
        drive(0, 0, 0, 3, 1);  tick("down from 0");

        // Random traffic with occasional loads
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(7) == 0), int'($urandom_range(7)), int'($urandom_range(7)),
                  int'($urandom_range(3)), $urandom_range(1) == 1);
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule

// File: doc/count_add_unit.md
# count_add_unit

Parametrised, fully registered successor to the lab-exam count/hold/add datapath. It supports four register modes (add, hold, count up, count down), a synchronous load, and a count enable, with wrap or saturation selectable at elaboration. Every output comes from a flop, so the block sits directly in front of the lab display and compare logic with no combinational path from `a`/`b`/`sel` to `dout`.

## Interface
Parameters:
- `W`, 3, operand width; result register is W+1 bits.
- `SAT`, 0, count behaviour at the limits: 0 = wrap modulo 2^(W+1), 1 = saturate at 0 / 2^(W+1)-1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `a`  in  W  operand A; also the load value.
- `b`  in  W  operand B.
- `sel`  in  2  mode: 00 add, 01 hold, 10 count up, 11 count down.
- `en`  in  1  count enable; applies to modes 10/11 only.
- `ld`  in  1  synchronous load of {1'b0, a}.
- `dout`  out  W+1  result/count register.
- `wrap`  out  1  one-cycle pulse: counter crossed a limit this cycle.
- `zero`  out  1  registered flag, high when the next-state `dout` is 0.

## Operation
- Reset (`rst` = 0, asynchronous): `dout` = 0, `wrap` = 0, `zero` = 1.
- Per-edge priority: `ld` > `sel`.
  - `ld` = 1: `dout` <= {1'b0, a}; `wrap` <= 0. Applies in every mode, including hold.
  - 00 add: `dout` <= a + b as an unsigned W+1-bit sum; the carry becomes the MSB, so the sum never overflows. `en` is ignored.
  - 01 hold: `dout` unchanged; `wrap` <= 0.
  - 10 up, `en` = 1:
    - below max: `dout` + 1.
    - at max (2^(W+1)-1), SAT = 0: `dout` <= 0 and `wrap` <= 1.
    - at max, SAT = 1: `dout` stays at max and `wrap` <= 1 on every held cycle.
  - 11 down, `en` = 1:
    - above 0: `dout` - 1.
    - at 0, SAT = 0: `dout` <= max and `wrap` <= 1.
    - at 0, SAT = 1: `dout` stays at 0 and `wrap` <= 1.
  - 10/11 with `en` = 0: behaves as hold; `wrap` <= 0.
- `wrap` is 0 on every cycle not listed above. It never stays high across a cycle unless the triggering condition repeats.
- `zero` is computed from the next-state value and registered with `dout`, so the two are always consistent.
- Mode changes take effect on the next edge; no internal state other than `dout`, `wrap`, `zero`.

## Timing
- Latency is 1 cycle from a `sel`/`a`/`b`/`ld` change at an edge to the updated `dout`.
- Count throughput is one step per enabled cycle.
- Reset asserted mid-count clears all outputs immediately, without waiting for `clk`. The first update after deassertion happens on the first rising edge with `rst` = 1.
- `ld` and count enable in the same cycle: the load wins and the count step is dropped.
- Add mode with `a` = b = 2^W-1 gives 2^(W+1)-2; no flag is raised.
- Inputs must be stable around the `clk` edge; there is no internal synchronisation.

## Structure
- Shared package `cau_pkg`:
  - mode constants `MODE_ADD` = 2'b00, `MODE_HOLD` = 2'b01, `MODE_UP` = 2'b10, `MODE_DOWN` = 2'b11.
  - a helper function for max value given W.
- Sub-module `rca_n`: a parametrised W-bit ripple-carry adder built from full-adder cells, with ports a, b, cin, s, cout.
  - One instance computes a + b.
  - A second instance does the count step: increment as `dout` + 0 with cin = 1; decrement as `dout` + all-ones.
- Top level holds:
  - the next-state mux
  - the limit detectors
  - the SAT generate branch
  - the three output flops.

## Test plan
1. W=3: assert `rst` low mid-cycle while `dout` = 9 → `dout` = 0, `wrap` = 0, `zero` = 1 immediately, before any edge.
2. sel=00, a=7, b=7 → `dout` = 14 one cycle later; then a=5, b=3 → 8; `wrap` stays 0 throughout.
3. SAT=0, sel=10, en=1 from `dout` = 14 → 15, then 0 with a one-cycle `wrap` pulse and `zero` = 1, then 1.
4. SAT=1, sel=11, en=1 from `dout` = 1 → 0, then 0 with `wrap` = 1 each cycle; set en=0 → `dout` = 0, `wrap` = 0.
5. sel=10, en=1, ld=1, a=5 in the same cycle → `dout` = 5, with no increment; next cycle (ld=0) → 6.
6. sel=01 for 4 cycles while `a`, `b`, `en` toggle → `dout` unchanged and `wrap` = 0; then sel=11, en=1 from 0 with SAT=0 → `dout` = 15 and `wrap` = 1.
